// File: rtl/fw_shift_chain_engine_pkg.sv
// Shared types and constants for the serial shift-chain engine.
// The enum state values are also the status readback encoding.
package fw_shift_chain_engine_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_DELAY     = 3'd1,
        ST_RESET_NOT = 3'd2,
        ST_LOAD      = 3'd3,
        ST_SHIFT     = 3'd4,
        ST_DONE      = 3'd5
    } state_t_sm_shift_chain;

    localparam logic CONFIG_REG_MODE_SHIFT    = 1'b0;
    localparam logic CONFIG_REG_MODE_PARALLEL = 1'b1;
    localparam logic SCAN_REG_MODE_SHIFT      = 1'b0;
    localparam logic SCAN_REG_MODE_PARALLEL   = 1'b1;

    localparam int unsigned cfg_reg_bits_total  = 5188;
    localparam int unsigned scan_reg_bits_total = 768;

    localparam int unsigned PERIOD_MIN = 2;

    // First non-empty phase of the sequence, skipping the phases that last zero periods.
    function automatic state_t_sm_shift_chain first_active_state(
        input logic delay_pending,
        input logic mask_reset_not,
        input logic load_mode
    );
        if (delay_pending)
            return ST_DELAY;
        else if (!mask_reset_not)
            return ST_RESET_NOT;
        else if (load_mode)
            return ST_LOAD;
        else
            return ST_SHIFT;
    endfunction

endpackage

// File: rtl/fw_shift_chain_engine_sclk_gen.sv
// Serial-clock phase counter: registered sclk plus phase strobes
// derived from the latched period and sample phase.
module fw_sclk_phase_gen #(
    parameter int unsigned PERIOD_W = 7
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                run,
    input  logic                sclk_en_c,
    input  logic [PERIOD_W-1:0] period,
    input  logic [PERIOD_W-1:0] sample,
    output logic                sclk,
    output logic                phase0_next_c,
    output logic                sample_c,
    output logic                period_end_c
);

    logic [PERIOD_W-1:0] phase;
    logic [PERIOD_W-1:0] phase_next;
    logic [PERIOD_W-1:0] high_from;

    // Low half of the period comes first, so the ASIC rising edge lands mid-bit.
    always_comb begin
        period_end_c  = (phase == period - PERIOD_W'(1));
        sample_c      = (phase == sample);
        phase0_next_c = !run || period_end_c;
        phase_next    = phase0_next_c ? '0 : phase + PERIOD_W'(1);
        high_from     = period - (period >> 1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase <= '0;
            sclk  <= 1'b0;
        end else begin
            phase <= phase_next;
            sclk  <= sclk_en_c && (phase_next >= high_from);
        end
    end

endmodule

// File: rtl/fw_shift_chain_engine.sv
// Generic serial-chain driver: optional reset_not pulse and parallel load,
// then an MSB-first shift with capture and optional rx-vs-tx compare.
module fw_shift_chain_engine
    import fw_shift_chain_engine_pkg::*;
#(
    parameter int unsigned CHAIN_BITS = cfg_reg_bits_total,
    parameter int unsigned PERIOD_W   = 7,
    parameter int unsigned DELAY_W    = 7
) (
    input  logic                  fw_pl_clk1,
    input  logic                  fw_rst,
    input  logic                  start_i,
    input  logic                  clear_i,
    input  logic [PERIOD_W-1:0]   cfg_period_i,
    input  logic [DELAY_W-1:0]    cfg_delay_i,
    input  logic [PERIOD_W-1:0]   cfg_sample_i,
    input  logic                  cfg_mode_i,
    input  logic                  cfg_loopback_i,
    input  logic                  cfg_compare_i,
    input  logic                  cfg_mask_reset_not_i,
    input  logic [CHAIN_BITS-1:0] data_tx_i,
    output logic [CHAIN_BITS-1:0] data_rx_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  error_o,
    output logic [2:0]            state_o,
    output logic                  asic_sclk_o,
    output logic                  asic_sin_o,
    input  logic                  asic_sout_i,
    output logic                  asic_mode_o,
    output logic                  asic_reset_not_o
);

    localparam int unsigned BIT_W = $clog2(CHAIN_BITS + 1);

    state_t_sm_shift_chain state, state_next;

    logic [PERIOD_W-1:0]   period_q, sample_q;
    logic [PERIOD_W-1:0]   period_clamp_c, sample_clamp_c;
    logic [DELAY_W-1:0]    delay_q, dcnt, dcnt_next;
    logic [BIT_W-1:0]      bcnt, bcnt_next;
    logic                  mode_q, loop_q, cmp_q, mask_q;
    logic [CHAIN_BITS-1:0] tx_q, tx_sr, tx_sr_next, tx_src_c, rx_next;
    logic                  latch_c, run_c, sclk_en_c;
    logic                  phase0_next_c, sample_c, period_end_c;
    logic                  sin_next, mode_next, reset_not_next;
    logic                  busy_next, done_next, error_next;

    assign period_clamp_c = (cfg_period_i < PERIOD_W'(PERIOD_MIN)) ? PERIOD_W'(PERIOD_MIN)
                                                                   : cfg_period_i;
    assign sample_clamp_c = (cfg_sample_i >= period_clamp_c) ? period_clamp_c - PERIOD_W'(1)
                                                             : cfg_sample_i;

    assign run_c     = (state != ST_IDLE) && (state != ST_DONE);
    assign sclk_en_c = (state_next == ST_LOAD) || (state_next == ST_SHIFT);
    assign state_o   = state;

    fw_sclk_phase_gen #(
        .PERIOD_W (PERIOD_W)
    ) u_phase_gen (
        .clk           (fw_pl_clk1),
        .rst           (fw_rst),
        .run           (run_c),
        .sclk_en_c     (sclk_en_c),
        .period        (period_q),
        .sample        (sample_q),
        .sclk          (asic_sclk_o),
        .phase0_next_c (phase0_next_c),
        .sample_c      (sample_c),
        .period_end_c  (period_end_c)
    );

    // Next-state and per-state period counting; every phase ends on a period boundary.
    always_comb begin
        state_next = state;
        dcnt_next  = dcnt;
        bcnt_next  = bcnt;
        latch_c    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_i) begin
                    latch_c    = 1'b1;
                    state_next = first_active_state(cfg_delay_i != '0, cfg_mask_reset_not_i,
                                                    cfg_mode_i);
                end
            end
            ST_DELAY: begin
                if (period_end_c) begin
                    if (dcnt == delay_q - DELAY_W'(1)) begin
                        dcnt_next  = '0;
                        state_next = first_active_state(1'b0, mask_q, mode_q);
                    end else begin
                        dcnt_next = dcnt + DELAY_W'(1);
                    end
                end
            end
            ST_RESET_NOT: begin
                if (period_end_c)
                    state_next = first_active_state(1'b0, 1'b1, mode_q);
            end
            ST_LOAD: begin
                if (period_end_c) begin
                    if (bcnt == BIT_W'(1)) begin
                        bcnt_next  = '0;
                        state_next = ST_SHIFT;
                    end else begin
                        bcnt_next = bcnt + BIT_W'(1);
                    end
                end
            end
            ST_SHIFT: begin
                if (period_end_c) begin
                    if (bcnt == BIT_W'(CHAIN_BITS - 1)) begin
                        bcnt_next  = '0;
                        state_next = ST_DONE;
                    end else begin
                        bcnt_next = bcnt + BIT_W'(1);
                    end
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Registered-output next values, decoded from the state being entered.
    always_comb begin
        tx_src_c       = latch_c ? data_tx_i : tx_sr;
        tx_sr_next     = tx_src_c;
        sin_next       = 1'b0;
        rx_next        = data_rx_o;
        done_next      = done_o;
        error_next     = error_o;
        busy_next      = (state_next != ST_IDLE);
        reset_not_next = (state_next != ST_RESET_NOT);
        mode_next      = (state_next == ST_SHIFT) ? CONFIG_REG_MODE_SHIFT
                                                  : CONFIG_REG_MODE_PARALLEL;
        if (state_next == ST_SHIFT) begin
            sin_next = asic_sin_o;
            if (phase0_next_c) begin
                sin_next   = tx_src_c[CHAIN_BITS-1];
                tx_sr_next = tx_src_c << 1;
            end
        end
        if (state == ST_SHIFT && sample_c)
            rx_next = {data_rx_o[CHAIN_BITS-2:0], loop_q ? asic_sin_o : asic_sout_i};
        // Completion wins over a coincident clear.
        if (state == ST_DONE) begin
            done_next  = 1'b1;
            error_next = error_o | (cmp_q && (data_rx_o != tx_q));
        end else if (clear_i) begin
            done_next  = 1'b0;
            error_next = 1'b0;
        end
    end

    always_ff @(posedge fw_pl_clk1 or posedge fw_rst) begin
        if (fw_rst) begin
            state            <= ST_IDLE;
            dcnt             <= '0;
            bcnt             <= '0;
            period_q         <= PERIOD_W'(PERIOD_MIN);
            sample_q         <= '0;
            delay_q          <= '0;
            mode_q           <= 1'b0;
            loop_q           <= 1'b0;
            cmp_q            <= 1'b0;
            mask_q           <= 1'b0;
            tx_q             <= '0;
            tx_sr            <= '0;
            data_rx_o        <= '0;
            busy_o           <= 1'b0;
            done_o           <= 1'b0;
            error_o          <= 1'b0;
            asic_sin_o       <= 1'b0;
            asic_mode_o      <= CONFIG_REG_MODE_PARALLEL;
            asic_reset_not_o <= 1'b1;
        end else begin
            state            <= state_next;
            dcnt             <= dcnt_next;
            bcnt             <= bcnt_next;
            tx_sr            <= tx_sr_next;
            data_rx_o        <= rx_next;
            busy_o           <= busy_next;
            done_o           <= done_next;
            error_o          <= error_next;
            asic_sin_o       <= sin_next;
            asic_mode_o      <= mode_next;
            asic_reset_not_o <= reset_not_next;
            if (latch_c) begin
                period_q <= period_clamp_c;
                sample_q <= sample_clamp_c;
                delay_q  <= cfg_delay_i;
                mode_q   <= cfg_mode_i;
                loop_q   <= cfg_loopback_i;
                cmp_q    <= cfg_compare_i;
                mask_q   <= cfg_mask_reset_not_i;
                tx_q     <= data_tx_i;
            end
        end
    end

endmodule

// File: tb/tb_fw_shift_chain_engine.sv
// Scoreboard bench for fw_shift_chain_engine on an 8-bit chain: a run-level
// reference model queues expected results, a monitor checks each completed run.
module tb_fw_shift_chain_engine;
    import fw_shift_chain_engine_pkg::*;

    localparam int unsigned NB = 8;
    localparam int          WAIT_MAX = 3000;

    typedef struct {
        int         period;
        int         delay;
        int         sample;
        bit         mode;
        bit         mask;
        bit         loop;
        bit         cmp;
        logic [7:0] tx;
        logic [1:0] sout_sel;
    } cfg_t;

    typedef struct {
        int         busy;
        int         rstn_low;
        int         load_pulses;
        int         sclk_high;
        int         shift_cyc;
        logic [7:0] tx;
        logic [7:0] rx;
        logic       err;
    } exp_t;

    logic          clk = 1'b0;
    logic          fw_rst = 1'b1;
    logic          start_i = 1'b0;
    logic          clear_i = 1'b0;
    logic [6:0]    cfg_period = '0;
    logic [6:0]    cfg_delay = '0;
    logic [6:0]    cfg_sample = '0;
    logic          cfg_mode = 1'b0;
    logic          cfg_loop = 1'b0;
    logic          cfg_cmp = 1'b0;
    logic          cfg_mask = 1'b0;
    logic [NB-1:0] data_tx = '0;
    logic [NB-1:0] data_rx;
    logic          busy_o, done_o, error_o;
    logic [2:0]    state_o;
    logic          asic_sclk, asic_sin, asic_sout, asic_mode, asic_rstn;
    logic [1:0]    sout_sel = 2'd0;

    int   checks = 0;
    int   failures = 0;
    exp_t exp_q[$];

    // ASIC stand-in: constant 0/1, or echo of sclk so the capture phase is observable.
    assign asic_sout = (sout_sel == 2'd2) ? asic_sclk : (sout_sel == 2'd1);

    always #5 clk = ~clk;

    fw_shift_chain_engine #(
        .CHAIN_BITS (NB),
        .PERIOD_W   (7),
        .DELAY_W    (7)
    ) dut (
        .fw_pl_clk1           (clk),
        .fw_rst               (fw_rst),
        .start_i              (start_i),
        .clear_i              (clear_i),
        .cfg_period_i         (cfg_period),
        .cfg_delay_i          (cfg_delay),
        .cfg_sample_i         (cfg_sample),
        .cfg_mode_i           (cfg_mode),
        .cfg_loopback_i       (cfg_loop),
        .cfg_compare_i        (cfg_cmp),
        .cfg_mask_reset_not_i (cfg_mask),
        .data_tx_i            (data_tx),
        .data_rx_o            (data_rx),
        .busy_o               (busy_o),
        .done_o               (done_o),
        .error_o              (error_o),
        .state_o              (state_o),
        .asic_sclk_o          (asic_sclk),
        .asic_sin_o           (asic_sin),
        .asic_sout_i          (asic_sout),
        .asic_mode_o          (asic_mode),
        .asic_reset_not_o     (asic_rstn)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string tag);
        checks++;
        failures++;
        $display("FAIL %s: wait bound of %0d cycles expired", tag, WAIT_MAX);
    endtask

    // Whole-run expectations from the sequence rules, in plain arithmetic.
    function automatic exp_t model(input cfg_t c);
        exp_t e;
        int   pe, se, r, l;
        pe = (c.period < 2) ? 2 : c.period;
        se = (c.sample >= pe) ? pe - 1 : c.sample;
        r  = c.mask ? 0 : 1;
        l  = c.mode ? 2 : 0;
        e.busy        = pe * (c.delay + r + l + NB) + 1;
        e.rstn_low    = pe * r;
        e.load_pulses = l;
        e.sclk_high   = (l + NB) * (pe / 2);
        e.shift_cyc   = pe * NB;
        e.tx          = c.tx;
        if (c.loop)
            e.rx = c.tx;
        else if (c.sout_sel == 2'd0)
            e.rx = 8'h00;
        else if (c.sout_sel == 2'd1)
            e.rx = 8'hFF;
        else
            e.rx = (se >= pe - pe / 2) ? 8'hFF : 8'h00;
        e.err = c.cmp && (e.rx != c.tx);
        return e;
    endfunction

    task automatic drive_cfg(input cfg_t c);
        cfg_period = 7'(c.period);
        cfg_delay  = 7'(c.delay);
        cfg_sample = 7'(c.sample);
        cfg_mode   = c.mode;
        cfg_mask   = c.mask;
        cfg_loop   = c.loop;
        cfg_cmp    = c.cmp;
        data_tx    = c.tx;
        sout_sel   = c.sout_sel;
    endtask

    // Inputs change after acceptance so a missed latch shows up.
    task automatic scramble();
        cfg_period = 7'($urandom);
        cfg_delay  = 7'($urandom);
        cfg_sample = 7'($urandom);
        cfg_mode   = 1'($urandom);
        cfg_mask   = 1'($urandom);
        cfg_loop   = 1'($urandom);
        cfg_cmp    = 1'($urandom);
        data_tx    = 8'($urandom);
    endtask

    task automatic wait_state(input logic [2:0] s, input string tag);
        int n = 0;
        while (state_o != s && n < WAIT_MAX) begin
            @(negedge clk);
            n++;
        end
        if (n >= WAIT_MAX) timeout(tag);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy_o && n < WAIT_MAX) begin
            @(negedge clk);
            n++;
        end
        if (n >= WAIT_MAX) timeout(tag);
    endtask

    task automatic run_one(input cfg_t c, input bit start_mid, input bit clr_in_done);
        @(negedge clk);
        clear_i = 1'b1;
        @(negedge clk);
        clear_i = 1'b0;
        drive_cfg(c);
        exp_q.push_back(model(c));
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        chk("busy_rise", 64'(busy_o), 64'd1);
        scramble();
        if (start_mid) begin
            wait_state(3'(ST_SHIFT), "wait_shift");
            start_i = 1'b1;
            @(negedge clk);
            start_i = 1'b0;
        end
        if (clr_in_done) begin
            wait_state(3'(ST_DONE), "wait_done");
            clear_i = 1'b1;
            @(negedge clk);
            clear_i = 1'b0;
        end
        wait_idle("wait_idle");
        if (start_mid) begin
            repeat (4) @(negedge clk);
            chk("start_ignored", 64'(busy_o), 64'd0);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_sclk"}, 64'(asic_sclk), 64'd0);
        chk({tag, "_sin"}, 64'(asic_sin), 64'd0);
        chk({tag, "_mode"}, 64'(asic_mode), 64'd1);
        chk({tag, "_rstn"}, 64'(asic_rstn), 64'd1);
        chk({tag, "_busy"}, 64'(busy_o), 64'd0);
        chk({tag, "_done"}, 64'(done_o), 64'd0);
        chk({tag, "_error"}, 64'(error_o), 64'd0);
        chk({tag, "_rx"}, 64'(data_rx), 64'd0);
        chk({tag, "_state"}, 64'(state_o), 64'(ST_IDLE));
    endtask

    // Monitor: gathers per-run activity and checks it when busy drops.
    initial begin : monitor
        logic       busy_p, sclk_p;
        int         busy_n, rstn_n, load_n, sclkh_n, shift_n, sin_n, leak_n;
        logic [7:0] sin_bits;
        exp_t       e;
        busy_p = 1'b0;
        sclk_p = 1'b0;
        {busy_n, rstn_n, load_n, sclkh_n, shift_n, sin_n, leak_n} = '0;
        sin_bits = '0;
        forever begin
            @(negedge clk);
            if (fw_rst) begin
                busy_p = 1'b0;
                sclk_p = 1'b0;
                continue;
            end
            if (busy_o && !busy_p) begin
                {busy_n, rstn_n, load_n, sclkh_n, shift_n, sin_n, leak_n} = '0;
                sin_bits = '0;
            end
            if (busy_o) begin
                busy_n++;
                if (!asic_rstn) rstn_n++;
                if (asic_sclk) sclkh_n++;
                if (!asic_mode) shift_n++;
                if (asic_mode && asic_sin) leak_n++;
                if (asic_sclk && !sclk_p) begin
                    if (asic_mode) begin
                        load_n++;
                    end else begin
                        sin_bits = {sin_bits[6:0], asic_sin};
                        sin_n++;
                    end
                end
            end
            if (!busy_o && busy_p) begin
                if (exp_q.size() == 0) begin
                    timeout("unexpected_completion");
                end else begin
                    e = exp_q.pop_front();
                    chk("busy_cycles", 64'(busy_n), 64'(e.busy));
                    chk("rstn_low", 64'(rstn_n), 64'(e.rstn_low));
                    chk("load_pulses", 64'(load_n), 64'(e.load_pulses));
                    chk("sclk_high", 64'(sclkh_n), 64'(e.sclk_high));
                    chk("shift_cycles", 64'(shift_n), 64'(e.shift_cyc));
                    chk("sin_count", 64'(sin_n), 64'(NB));
                    chk("sin_bits", 64'(sin_bits), 64'(e.tx));
                    chk("sin_idle", 64'(leak_n), 64'd0);
                    chk("rx", 64'(data_rx), 64'(e.rx));
                    chk("done", 64'(done_o), 64'd1);
                    chk("error", 64'(error_o), 64'(e.err));
                end
            end
            busy_p = busy_o;
            sclk_p = asic_sclk;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        cfg_t base, c;
        repeat (3) @(negedge clk);
        chk_reset_outputs("por");
        fw_rst = 1'b0;

        base = '{period: 4, delay: 1, sample: 1, mode: 1'b0, mask: 1'b0, loop: 1'b1,
                 cmp: 1'b1, tx: 8'hA5, sout_sel: 2'd0};
        run_one(base, 1'b0, 1'b0);

        c = base; c.loop = 1'b0;
        run_one(c, 1'b0, 1'b0);
        c.cmp = 1'b0;
        run_one(c, 1'b0, 1'b0);

        c = base; c.mode = 1'b1; c.mask = 1'b1; c.delay = 0; c.period = 6; c.tx = 8'h3C;
        run_one(c, 1'b0, 1'b0);

        c = base; c.period = 0; c.delay = 2; c.sample = 0; c.tx = 8'h96;
        run_one(c, 1'b0, 1'b0);
        c.period = 2;
        run_one(c, 1'b0, 1'b0);

        c = base; c.loop = 1'b0; c.sample = 9; c.sout_sel = 2'd2;
        run_one(c, 1'b0, 1'b0);
        c.sample = 1;
        run_one(c, 1'b0, 1'b0);

        c = base; c.tx = 8'h5A;
        run_one(c, 1'b1, 1'b0);

        c = base; c.loop = 1'b0;
        run_one(c, 1'b0, 1'b1);

        // Abort mid-shift with done/error still set from the previous run.
        @(negedge clk);
        c = base; c.delay = 0; c.mask = 1'b1; c.tx = 8'hFF;
        drive_cfg(c);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        wait_state(3'(ST_SHIFT), "abort_wait_shift");
        repeat (12) @(negedge clk);
        #2 fw_rst = 1'b1;
        #1 chk_reset_outputs("abort");
        @(negedge clk);
        @(negedge clk);
        fw_rst = 1'b0;

        c = base; c.loop = 1'b0;
        run_one(c, 1'b0, 1'b0);
        @(negedge clk);
        clear_i = 1'b1;
        @(negedge clk);
        clear_i = 1'b0;
        chk("clear_done", 64'(done_o), 64'd0);
        chk("clear_error", 64'(error_o), 64'd0);

        for (int i = 0; i < 12; i++) begin
            c.period   = int'($urandom_range(0, 7));
            c.delay    = int'($urandom_range(0, 3));
            c.sample   = int'($urandom_range(0, 9));
            c.mode     = 1'($urandom);
            c.mask     = 1'($urandom);
            c.loop     = 1'($urandom);
            c.cmp      = 1'($urandom);
            c.tx       = 8'($urandom);
            c.sout_sel = 2'($urandom_range(0, 2));
            run_one(c, 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0));
        end

        repeat (4) @(negedge clk);
        chk("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
